// File: rtl/aurora_hls_pkg.sv
// ---------------------------------------------------------------------------
// aurora_hls_pkg
// Shared definitions for the Aurora RX receive buffer:
//   - default stream width, depth and watermark thresholds
//   - output-stage state encoding (ST_EMPTY / ST_VALID)
//   - helper that sizes one stored beat (tdata + tkeep + tlast)
// ---------------------------------------------------------------------------
package aurora_hls_pkg;

    localparam int DEFAULT_DATA_WIDTH        = 256;
    localparam int DEFAULT_DEPTH             = 512;
    localparam int DEFAULT_PROG_FULL_THRESH  = 384;
    localparam int DEFAULT_PROG_EMPTY_THRESH = 128;

    // Output stage: the head register either holds a beat or it does not.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } outState_e;

    // One RAM word carries the whole beat so tkeep/tlast travel with tdata.
    function automatic int ramWidth(input int dataWidth);
        return dataWidth + dataWidth / 8 + 1;
    endfunction

endpackage

// File: rtl/aurora_hls_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// aurora_hls_rx_fifo_if
// Stream bundle around the receive buffer.
//   s_axis_* : beats arriving from the Aurora RX core (no tready exists)
//   m_axis_* : head beat offered to the HLS kernel, with its tready
// Modports:
//   slave  : the FIFO's view (consumes s_axis_*, produces m_axis_*)
//   master : the surrounding logic's view (the mirror image)
// ---------------------------------------------------------------------------
interface aurora_hls_rx_fifo_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic [DATA_WIDTH/8-1:0] s_axis_tkeep;
    logic                    s_axis_tlast;
    logic                    s_axis_tvalid;

    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

endinterface

// File: rtl/aurora_hls_ram_sdp.sv
// ---------------------------------------------------------------------------
// aurora_hls_ram_sdp
// Simple dual-port RAM: one write port, one read port, registered read.
// The read register only changes when rdEn_i is high, so it can serve
// directly as a stable FIFO head register.
// Ports:
//   clk       clock
//   wrEn_i    write strobe
//   wrAddr_i  write address
//   wrData_i  write word
//   rdEn_i    read strobe (loads rdData_o at the next edge)
//   rdAddr_i  read address
//   rdData_o  registered read word
// ---------------------------------------------------------------------------
module aurora_hls_ram_sdp #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn_i,
    input  logic [AW-1:0]    wrAddr_i,
    input  logic [WIDTH-1:0] wrData_i,
    input  logic             rdEn_i,
    input  logic [AW-1:0]    rdAddr_i,
    output logic [WIDTH-1:0] rdData_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdData_q;

    // Storage array; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // Registered read port, holds its value between reads.
    always_ff @(posedge clk) begin
        if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/aurora_hls_rx_fifo.sv
// ---------------------------------------------------------------------------
// aurora_hls_rx_fifo
// Receive buffer between the Aurora RX stream (no backpressure) and the HLS
// kernel. Beats are stored in a simple dual-port RAM and presented
// first-word-fall-through; the RAM read register is the head register.
// Registered watermarks feed the NFC generator (XOFF/XON), rx_valid feeds
// its latency counter, and beats arriving while full are dropped and counted.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   counter_reset    clears overflow_count and max_fill_level only
//   bus              stream bundle (slave view): s_axis_* in, m_axis_* out
//   prog_full        registered, level >= PROG_FULL_THRESH
//   prog_empty       registered, level <= PROG_EMPTY_THRESH
//   rx_valid         s_axis_tvalid delayed one cycle
//   fill_level       current beat count (head register included)
//   overflow_count   dropped beats, saturating at all-ones
//   max_fill_level   peak level since last clear
//
// Build option: define AURORA_HLS_RX_FIFO_PEAK_EN to track max_fill_level;
// otherwise it reads constant 0 and no comparator is built.
// ---------------------------------------------------------------------------
module aurora_hls_rx_fifo
    import aurora_hls_pkg::*;
#(
    parameter  int DATA_WIDTH        = DEFAULT_DATA_WIDTH,
    parameter  int DEPTH             = DEFAULT_DEPTH,
    parameter  int PROG_FULL_THRESH  = DEFAULT_PROG_FULL_THRESH,
    parameter  int PROG_EMPTY_THRESH = DEFAULT_PROG_EMPTY_THRESH,
    localparam int AW                = $clog2(DEPTH),
    localparam int LW                = AW + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                counter_reset,
    aurora_hls_rx_fifo_if.slave bus,
    output logic                prog_full,
    output logic                prog_empty,
    output logic                rx_valid,
    output logic [LW-1:0]       fill_level,
    output logic [31:0]         overflow_count,
    output logic [LW-1:0]       max_fill_level
);

    localparam int RW = ramWidth(DATA_WIDTH);

    outState_e      state_q, state_d;
    logic [AW-1:0]  wrPtr_q, rdPtr_q;
    logic [LW-1:0]  level_q, level_d;
    logic           progFull_q, progEmpty_q, rxValid_q;
    logic [31:0]    overflowCount_q;

    logic           push, pop, drop, ramHasWord, ramRdEn;
    logic [RW-1:0]  ramWrData, ramRdData;

    // Handshake decode. level_q counts the head register too, so the RAM
    // holds level_q-1 words while VALID and level_q words while EMPTY.
    // A pop frees a slot in the same cycle, so a full FIFO still accepts
    // a beat when the consumer takes one.
    always_comb begin
        pop        = (state_q == ST_VALID) && bus.m_axis_tready;
        push       = bus.s_axis_tvalid && ((level_q < LW'(DEPTH)) || pop);
        drop       = bus.s_axis_tvalid && !push;
        ramHasWord = (state_q == ST_VALID) ? (level_q > LW'(1)) : (level_q != '0);
        level_d    = level_q + LW'(push) - LW'(pop);
    end

    // Output-stage next state. A word written this cycle is not yet
    // readable, so it reaches the head one cycle after it lands in RAM.
    always_comb begin
        state_d = state_q;
        ramRdEn = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (ramHasWord) begin
                    state_d = ST_VALID;
                    ramRdEn = 1'b1;
                end
            end
            ST_VALID: begin
                if (pop) begin
                    if (ramHasWord) begin
                        ramRdEn = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, pointers, level and the registered flags. Flags are computed
    // from the next level so they change together with fill_level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            progFull_q  <= 1'b0;
            progEmpty_q <= 1'b1;
            rxValid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (ramRdEn) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            level_q     <= level_d;
            progFull_q  <= (level_d >= LW'(PROG_FULL_THRESH));
            progEmpty_q <= (level_d <= LW'(PROG_EMPTY_THRESH));
            rxValid_q   <= bus.s_axis_tvalid;
        end
    end

    // Dropped-beat counter; counter_reset wins over a coinciding drop.
    always_ff @(posedge clk) begin
        if (!rst_n || counter_reset) begin
            overflowCount_q <= '0;
        end else if (drop && (overflowCount_q != '1)) begin
            overflowCount_q <= overflowCount_q + 32'd1;
        end
    end

`ifdef AURORA_HLS_RX_FIFO_PEAK_EN
    logic [LW-1:0] maxFill_q;

    // Peak level tracker, cleared by either reset.
    always_ff @(posedge clk) begin
        if (!rst_n || counter_reset) begin
            maxFill_q <= '0;
        end else if (level_d > maxFill_q) begin
            maxFill_q <= level_d;
        end
    end

    assign max_fill_level = maxFill_q;
`else
    assign max_fill_level = '0;
`endif

    assign ramWrData = {bus.s_axis_tlast, bus.s_axis_tkeep, bus.s_axis_tdata};

    aurora_hls_ram_sdp #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk      (clk),
        .wrEn_i   (push),
        .wrAddr_i (wrPtr_q),
        .wrData_i (ramWrData),
        .rdEn_i   (ramRdEn),
        .rdAddr_i (rdPtr_q),
        .rdData_o (ramRdData)
    );

    assign {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata} = ramRdData;
    assign bus.m_axis_tvalid = (state_q == ST_VALID);

    assign prog_full      = progFull_q;
    assign prog_empty     = progEmpty_q;
    assign rx_valid       = rxValid_q;
    assign fill_level     = level_q;
    assign overflow_count = overflowCount_q;

endmodule

// File: tb/tb_aurora_hls_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_aurora_hls_rx_fifo
// Directed bench for aurora_hls_rx_fifo with DEPTH=16, PROG_FULL_THRESH=12,
// PROG_EMPTY_THRESH=4, DATA_WIDTH=16. Inputs change and outputs are sampled
// 1 ns after each rising edge. Peak-level expectations follow the
// AURORA_HLS_RX_FIFO_PEAK_EN build option.
// ---------------------------------------------------------------------------
module tb_aurora_hls_rx_fifo;

    localparam int DW = 16;
    localparam int DP = 16;
    localparam int LW = $clog2(DP) + 1;

    logic          clk;
    logic          rst_n;
    logic          counter_reset;
    logic          prog_full;
    logic          prog_empty;
    logic          rx_valid;
    logic [LW-1:0] fill_level;
    logic [31:0]   overflow_count;
    logic [LW-1:0] max_fill_level;

    int nCompared   = 0;
    int nMismatched = 0;

    aurora_hls_rx_fifo_if #(.DATA_WIDTH(DW)) bus ();

    aurora_hls_rx_fifo #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DP),
        .PROG_FULL_THRESH  (12),
        .PROG_EMPTY_THRESH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .counter_reset  (counter_reset),
        .bus            (bus),
        .prog_full      (prog_full),
        .prog_empty     (prog_empty),
        .rx_valid       (rx_valid),
        .fill_level     (fill_level),
        .overflow_count (overflow_count),
        .max_fill_level (max_fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input int d, input logic [1:0] k, input logic l);
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = 16'(d);
        bus.s_axis_tkeep  = k;
        bus.s_axis_tlast  = l;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        counter_reset = 1'b0;
        bus.m_axis_tready = 1'b0;
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        cycle();
        cycle();
        nCompared++; if (prog_empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_prog_empty: got %0b want 1", prog_empty); end
        nCompared++; if (prog_full !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_prog_full: got %0b want 0", prog_full); end
        nCompared++; if (bus.m_axis_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_tvalid: got %0b want 0", bus.m_axis_tvalid); end
        nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_fill: got %0d want 0", fill_level); end
        nCompared++; if (overflow_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_ovf: got %0d want 0", overflow_count); end
        nCompared++; if (rx_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rx_valid: got %0b want 0", rx_valid); end
        nCompared++; if (max_fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_max: got %0d want 0", max_fill_level); end
    endtask

    task automatic test_single_beat();
        apply_reset();
        bus.m_axis_tready = 1'b1;
        cycle();
        drive_beat(1'b1, 'hA5, 2'b11, 1'b1);
        cycle();
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        nCompared++; if (bus.m_axis_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_early_tvalid: got %0b want 0", bus.m_axis_tvalid); end
        nCompared++; if (fill_level !== 5'd1) begin nMismatched++; $display("[TB] FAIL single_fill1: got %0d want 1", fill_level); end
        nCompared++; if (rx_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_rx_valid_hi: got %0b want 1", rx_valid); end
        cycle();
        nCompared++; if (bus.m_axis_tvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_tvalid: got %0b want 1", bus.m_axis_tvalid); end
        nCompared++; if (bus.m_axis_tdata !== 16'h00A5) begin nMismatched++; $display("[TB] FAIL single_tdata: got %h want 00a5", bus.m_axis_tdata); end
        nCompared++; if (bus.m_axis_tkeep !== 2'b11) begin nMismatched++; $display("[TB] FAIL single_tkeep: got %b want 11", bus.m_axis_tkeep); end
        nCompared++; if (bus.m_axis_tlast !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_tlast: got %b want 1", bus.m_axis_tlast); end
        nCompared++; if (rx_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_rx_valid_lo: got %0b want 0", rx_valid); end
        cycle();
        nCompared++; if (bus.m_axis_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_popped_tvalid: got %0b want 0", bus.m_axis_tvalid); end
        nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL single_fill0: got %0d want 0", fill_level); end
    endtask

    task automatic test_watermarks();
        logic expFull, expEmpty;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            drive_beat(1'b1, i, 2'b11, 1'b0);
            cycle();
            expFull  = (i + 1 >= 12);
            expEmpty = (i + 1 <= 4);
            nCompared++; if (fill_level !== 5'(i + 1)) begin nMismatched++; $display("[TB] FAIL wm_fill_up%0d: got %0d want %0d", i, fill_level, i + 1); end
            nCompared++; if (prog_full !== expFull) begin nMismatched++; $display("[TB] FAIL wm_full_up%0d: got %0b want %0b", i, prog_full, expFull); end
            nCompared++; if (prog_empty !== expEmpty) begin nMismatched++; $display("[TB] FAIL wm_empty_up%0d: got %0b want %0b", i, prog_empty, expEmpty); end
        end
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        bus.m_axis_tready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nCompared++; if (bus.m_axis_tdata !== 16'(k)) begin nMismatched++; $display("[TB] FAIL wm_data%0d: got %h want %h", k, bus.m_axis_tdata, 16'(k)); end
            cycle();
            expFull  = (11 - k >= 12);
            expEmpty = (11 - k <= 4);
            nCompared++; if (fill_level !== 5'(11 - k)) begin nMismatched++; $display("[TB] FAIL wm_fill_dn%0d: got %0d want %0d", k, fill_level, 11 - k); end
            nCompared++; if (prog_full !== expFull) begin nMismatched++; $display("[TB] FAIL wm_full_dn%0d: got %0b want %0b", k, prog_full, expFull); end
            nCompared++; if (prog_empty !== expEmpty) begin nMismatched++; $display("[TB] FAIL wm_empty_dn%0d: got %0b want %0b", k, prog_empty, expEmpty); end
        end
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            drive_beat(1'b1, i, 2'(i), (i % 4 == 3));
            cycle();
        end
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        nCompared++; if (fill_level !== 5'd16) begin nMismatched++; $display("[TB] FAIL ovf_fill: got %0d want 16", fill_level); end
        nCompared++; if (overflow_count !== 32'd4) begin nMismatched++; $display("[TB] FAIL ovf_count: got %0d want 4", overflow_count); end
        nCompared++; if (prog_full !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_prog_full: got %0b want 1", prog_full); end
        bus.m_axis_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            nCompared++; if (bus.m_axis_tvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_tvalid%0d: got %0b want 1", k, bus.m_axis_tvalid); end
            nCompared++; if (bus.m_axis_tdata !== 16'(k)) begin nMismatched++; $display("[TB] FAIL ovf_data%0d: got %h want %h", k, bus.m_axis_tdata, 16'(k)); end
            nCompared++; if (bus.m_axis_tkeep !== 2'(k)) begin nMismatched++; $display("[TB] FAIL ovf_keep%0d: got %b want %b", k, bus.m_axis_tkeep, 2'(k)); end
            nCompared++; if (bus.m_axis_tlast !== (k % 4 == 3)) begin nMismatched++; $display("[TB] FAIL ovf_last%0d: got %b want %b", k, bus.m_axis_tlast, (k % 4 == 3)); end
            cycle();
        end
        nCompared++; if (bus.m_axis_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_drained_tvalid: got %0b want 0", bus.m_axis_tvalid); end
        nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL ovf_drained_fill: got %0d want 0", fill_level); end
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive_beat(1'b1, i, 2'b11, 1'b0);
            cycle();
        end
        bus.m_axis_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_beat(1'b1, 16 + k, 2'b11, 1'b0);
            nCompared++; if (bus.m_axis_tdata !== 16'(k)) begin nMismatched++; $display("[TB] FAIL b2b_data%0d: got %h want %h", k, bus.m_axis_tdata, 16'(k)); end
            cycle();
            nCompared++; if (fill_level !== 5'd16) begin nMismatched++; $display("[TB] FAIL b2b_fill%0d: got %0d want 16", k, fill_level); end
        end
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        nCompared++; if (overflow_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL b2b_ovf: got %0d want 0", overflow_count); end
        for (int k = 10; k < 26; k++) begin
            nCompared++; if (bus.m_axis_tdata !== 16'(k)) begin nMismatched++; $display("[TB] FAIL b2b_drain%0d: got %h want %h", k, bus.m_axis_tdata, 16'(k)); end
            cycle();
        end
        nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL b2b_final_fill: got %0d want 0", fill_level); end
        bus.m_axis_tready = 1'b0;
    endtask

    task automatic test_counter_reset();
        logic [LW-1:0] expMax;
        apply_reset();
        for (int i = 0; i < 18; i++) begin
            drive_beat(1'b1, i, 2'b01, 1'b0);
            cycle();
        end
        nCompared++; if (overflow_count !== 32'd2) begin nMismatched++; $display("[TB] FAIL cr_ovf_pre: got %0d want 2", overflow_count); end
        counter_reset = 1'b1;
        cycle();
        counter_reset = 1'b0;
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        nCompared++; if (overflow_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL cr_ovf_cleared: got %0d want 0", overflow_count); end
        nCompared++; if (fill_level !== 5'd16) begin nMismatched++; $display("[TB] FAIL cr_fill_kept: got %0d want 16", fill_level); end
        nCompared++; if (max_fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL cr_max_cleared: got %0d want 0", max_fill_level); end
        cycle();
`ifdef AURORA_HLS_RX_FIFO_PEAK_EN
        expMax = 5'd16;
`else
        expMax = 5'd0;
`endif
        nCompared++; if (max_fill_level !== expMax) begin nMismatched++; $display("[TB] FAIL cr_max_regrow: got %0d want %0d", max_fill_level, expMax); end
        drive_beat(1'b1, 99, 2'b01, 1'b0);
        cycle();
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        nCompared++; if (overflow_count !== 32'd1) begin nMismatched++; $display("[TB] FAIL cr_ovf_recount: got %0d want 1", overflow_count); end
    endtask

    task automatic test_reset_mid();
        logic [LW-1:0] expMax;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive_beat(1'b1, i, 2'b11, 1'b0);
            cycle();
        end
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        cycle();
`ifdef AURORA_HLS_RX_FIFO_PEAK_EN
        expMax = 5'd9;
`else
        expMax = 5'd0;
`endif
        nCompared++; if (fill_level !== 5'd9) begin nMismatched++; $display("[TB] FAIL rm_fill_pre: got %0d want 9", fill_level); end
        nCompared++; if (max_fill_level !== expMax) begin nMismatched++; $display("[TB] FAIL rm_max_pre: got %0d want %0d", max_fill_level, expMax); end
        rst_n = 1'b0;
        bus.m_axis_tready = 1'b1;
        drive_beat(1'b1, 'h77, 2'b11, 1'b1);
        cycle();
        rst_n = 1'b1;
        bus.m_axis_tready = 1'b0;
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        nCompared++; if (fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL rm_fill_post: got %0d want 0", fill_level); end
        nCompared++; if (bus.m_axis_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_tvalid_post: got %0b want 0", bus.m_axis_tvalid); end
        nCompared++; if (prog_empty !== 1'b1) begin nMismatched++; $display("[TB] FAIL rm_prog_empty_post: got %0b want 1", prog_empty); end
        nCompared++; if (rx_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rm_rx_valid_post: got %0b want 0", rx_valid); end
        nCompared++; if (max_fill_level !== 5'd0) begin nMismatched++; $display("[TB] FAIL rm_max_post: got %0d want 0", max_fill_level); end
    endtask

    initial begin
        rst_n = 1'b0;
        counter_reset = 1'b0;
        bus.m_axis_tready = 1'b0;
        drive_beat(1'b0, 0, 2'b00, 1'b0);
        test_reset();
        test_single_beat();
        test_watermarks();
        test_overflow();
        test_back_to_back();
        test_counter_reset();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
